mod_counter_p: RTL and testbench
================================

MOD_COUNTER_P -- requirements
Module: mod_counter_p

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning counter width in bits.
REQ-002 SHALL have parameter LO, default 0, meaning lowest count value.
REQ-003 SHALL have parameter HI, default 9, meaning highest count value; LO < HI < 2**WIDTH.
REQ-004 SHALL have parameter RST_VAL, default 0, meaning count value after reset; LO <= RST_VAL <= HI.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port en  input  1  count enable.
REQ-008 SHALL have port dir  input  1  count direction: 0 up, 1 down.
REQ-009 SHALL have port sat_mode  input  1  0 wrap at bounds, 1 stop at bounds.
REQ-010 SHALL have port load  input  1  synchronous load strobe.
REQ-011 SHALL have port d  input  WIDTH  load value.
REQ-012 SHALL have port clr_ovf  input  1  clears sticky overflow flag.
REQ-013 SHALL have port q  output  WIDTH  current count, registered.
REQ-014 SHALL have port tc  output  1  terminal count: q==HI when dir=0, q==LO when dir=1; combinational from q and dir.
REQ-015 SHALL have port wrap  output  1  one-cycle registered pulse, high the cycle after a wrap occurred.
REQ-016 SHALL have port ovf  output  1  sticky flag, set by any wrap.
REQ-017 SHALL have port sat  output  1  registered; high while held at a bound in sat_mode.

Function
REQ-018 SHALL prioritise per edge: reset > load > en > hold.
REQ-019 SHALL on load set q=d if LO<=d<=HI, else q=LO when dir=0 and q=HI when dir=1; no wrap pulse; sat=0.
REQ-020 SHALL with en=1, load=0, tc=0 step q by +1 (dir=0) or -1 (dir=1) with latency one clock; wrap=0, sat=0.
REQ-021 SHALL with en=1, load=0, tc=1, sat_mode=0 set q=LO (dir=0) or q=HI (dir=1), wrap=1 next cycle, ovf=1.
REQ-022 SHALL with en=1, load=0, tc=1, sat_mode=1 hold q, set sat=1, wrap=0, ovf unchanged.
REQ-023 SHALL with en=0 and load=0 hold q; wrap=0; sat keeps its value.
REQ-024 SHALL let dir change any cycle; next step uses new dir and tc re-evaluates immediately.
REQ-025 SHALL clear ovf on clr_ovf=1 unless a wrap occurs the same edge, in which case ovf=1 (set wins).
REQ-026 SHALL keep q within [LO,HI] at all times after reset.
REQ-027 SHALL be fully synchronous; no clock derived from counter bits, no asynchronous set/clear.
REQ-028 SHALL handle count arithmetic in WIDTH bits; LO and HI compare unsigned.

Reset
REQ-029 SHALL on rising clk with rst_n=0 set q=RST_VAL, wrap=0, ovf=0, sat=0, overriding load, en, clr_ovf.
REQ-030 SHALL when reset is asserted mid-count discard the in-progress step; first step after release starts from RST_VAL.

Verification
REQ-031 SHALL cover: reset, en=1, dir=0, sat_mode=0, 12 clocks -> q 0..9, 0, 1; wrap high one cycle after 9->0; ovf=1 thereafter.
REQ-032 SHALL cover: load d=3, dir=1, en=1, sat_mode=1, 6 clocks -> q 3,2,1,0,0,0; sat=1 from cycle q first held at 0; wrap=0, ovf=0.
REQ-033 SHALL cover: load d=12 (out of range) with dir=0 -> q=0; with dir=1 -> q=9.
REQ-034 SHALL cover: q=9, dir=0, en=1, sat_mode=0, clr_ovf=1 same edge -> q=0, ovf=1; next edge clr_ovf=1, en=0 -> ovf=0.
REQ-035 SHALL cover: q=5, en=1, load=1, d=7 same edge -> q=7 (load wins); then rst_n=0 with load=1 -> q=0, all flags 0.
REQ-036 SHALL cover: q=4, dir toggled each cycle with en=1 -> q alternates 5,4,5,4; tc=0 throughout.

Source files
------------

// File: rtl/mod_counter_p.sv
// Bounded up/down counter over [LO,HI] with load, wrap-or-saturate at the bounds, and wrap/overflow/saturation flags.
// One clock from en/load to q; tc is combinational from q and dir; there is no backpressure, and a step is taken on every enabled edge.
module mod_counter_p #(
  parameter int WIDTH   = 6,
  parameter int LO      = 0,
  parameter int HI      = 9,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             sat
);

  localparam logic [WIDTH-1:0] LO_V   = LO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] HI_V   = HI[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V  = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SPAN_V = HI_V - LO_V;

  logic [WIDTH-1:0] d_ofs;
  logic             d_in_range;
  logic [WIDTH-1:0] bound_far;

  // Offset compare: any d below LO wraps to a large offset, so one unsigned test covers both bounds.
  assign d_ofs      = d - LO_V;
  assign d_in_range = (d_ofs <= SPAN_V);
  assign bound_far  = dir ? HI_V : LO_V;
  assign tc         = dir ? (q == LO_V) : (q == HI_V);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= RST_V;
      wrap <= 1'b0;
      ovf  <= 1'b0;
      sat  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_ovf) begin
        ovf <= 1'b0;
      end
      if (load) begin
        q   <= d_in_range ? d : bound_far;
        sat <= 1'b0;
      end else if (en) begin
        if (!tc) begin
          q   <= dir ? (q - 1'b1) : (q + 1'b1);
          sat <= 1'b0;
        end else if (!sat_mode) begin
          // A wrap sets ovf even when clr_ovf is asserted on the same edge.
          q    <= bound_far;
          wrap <= 1'b1;
          ovf  <= 1'b1;
          sat  <= 1'b0;
        end else begin
          sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_p.sv
// Randomized and directed bench for mod_counter_p against an integer reference model.
module tb_mod_counter_p;

  localparam int LO      = 0;
  localparam int HI      = 9;
  localparam int RST_VAL = 0;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       sat_mode;
  logic       load;
  logic [5:0] d;
  logic       clr_ovf;
  logic [5:0] q;
  logic       tc;
  logic       wrap;
  logic       ovf;
  logic       sat;

  int n_vec;
  int n_err;

  int m_q;
  bit m_wrap;
  bit m_ovf;
  bit m_sat;
  bit m_valid;

  mod_counter_p #(.WIDTH(6), .LO(LO), .HI(HI), .RST_VAL(RST_VAL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .sat_mode (sat_mode),
    .load     (load),
    .d        (d),
    .clr_ovf  (clr_ovf),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .ovf      (ovf),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: try the plain integer step, and if it leaves [LO,HI] either saturate or jump to the far bound.
  task automatic model_edge(input bit r, input bit l, input bit e, input bit dr,
                            input bit sm, input bit co, input int dd);
    int nxt;
    if (!r) begin
      m_q = RST_VAL; m_wrap = 0; m_ovf = 0; m_sat = 0; m_valid = 1;
      return;
    end
    m_wrap = 0;
    if (co) m_ovf = 0;
    if (l) begin
      if (dd >= LO && dd <= HI) m_q = dd;
      else m_q = dr ? HI : LO;
      m_sat = 0;
    end else if (e) begin
      nxt = dr ? m_q - 1 : m_q + 1;
      if (nxt > HI || nxt < LO) begin
        if (sm) m_sat = 1;
        else begin
          m_q = dr ? HI : LO; m_wrap = 1; m_ovf = 1; m_sat = 0;
        end
      end else begin
        m_q = nxt; m_sat = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit e, input bit dr,
                     input bit sm, input bit co, input logic [5:0] dd);
    @(negedge clk);
    rst_n = r; load = l; en = e; dir = dr; sat_mode = sm; clr_ovf = co; d = dd;
    #1;
    if (m_valid) chk("tc", {31'd0, tc}, dr ? (m_q == LO) : (m_q == HI));
    @(posedge clk);
    model_edge(r, l, e, dr, sm, co, int'(dd));
    #1;
    chk("q",    {26'd0, q},    m_q);
    chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
    chk("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
    chk("sat",  {31'd0, sat},  {31'd0, m_sat});
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 6'd0);
    cyc(0, 1, 1, 1, 0, 1, 6'd5);
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_valid = 0;
    m_q = 0; m_wrap = 0; m_ovf = 0; m_sat = 0;
    rst_n = 0; en = 0; dir = 0; sat_mode = 0; load = 0; d = '0; clr_ovf = 0;

    do_reset();
    chk("reset_q", {26'd0, q}, RST_VAL);
    chk("reset_flags", {29'd0, wrap, ovf, sat}, 0);

    // Count up through the wrap.
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 1, 0, 0, 0, 6'd0);
      if (i == 9) chk("up_wrap_pulse", {31'd0, wrap}, 1);
    end
    chk("up_q_after12", {26'd0, q}, 2);
    chk("up_ovf_sticky", {31'd0, ovf}, 1);

    // Load then count down into saturation.
    do_reset();
    cyc(1, 1, 1, 1, 1, 0, 6'd3);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 1, 0, 6'd0);
    chk("sat_q", {26'd0, q}, 0);
    chk("sat_flag", {31'd0, sat}, 1);
    chk("sat_no_ovf", {30'd0, wrap, ovf}, 0);

    // Out-of-range loads clamp to the start bound for the direction.
    cyc(1, 1, 0, 0, 0, 0, 6'd12);
    chk("load_oor_up", {26'd0, q}, 0);
    cyc(1, 1, 0, 1, 0, 0, 6'd12);
    chk("load_oor_dn", {26'd0, q}, 9);

    // Wrap beats clr_ovf on the same edge.
    cyc(1, 1, 0, 0, 0, 0, 6'd9);
    cyc(1, 0, 1, 0, 0, 1, 6'd0);
    chk("clr_vs_wrap_q", {26'd0, q}, 0);
    chk("clr_vs_wrap_ovf", {31'd0, ovf}, 1);
    cyc(1, 0, 0, 0, 0, 1, 6'd0);
    chk("clr_ovf", {31'd0, ovf}, 0);

    // Load beats enable; reset beats load.
    cyc(1, 1, 0, 0, 0, 0, 6'd5);
    cyc(1, 1, 1, 0, 0, 0, 6'd7);
    chk("load_wins", {26'd0, q}, 7);
    cyc(0, 1, 1, 0, 0, 0, 6'd3);
    chk("rst_wins", {26'd0, q, wrap, ovf, sat}, RST_VAL << 3);

    // Direction toggled every cycle.
    cyc(1, 1, 0, 0, 0, 0, 6'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, i[0], 0, 0, 6'd0);
      chk("toggle_q", {26'd0, q}, (i % 2 == 0) ? 5 : 4);
      chk("toggle_tc", {31'd0, tc}, 0);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) >= 3), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 4) == 0), 6'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
